uio_bus_arbiter: RTL and testbench

Shares the 8-bit bidirectional uio pad bank (uio_in/uio_out/uio_oe) between NUM_REQ internal requesters inside the top-level project wrapper. A round-robin arbiter grants one requester at a time for a burst of byte beats. A sequencer inserts bus-turnaround cycles whenever the pad direction changes. All pad-side outputs are registered, and the block is gated by the wrapper's ena.

---
 rtl/uio_bus_arbiter_pkg.sv | 16 +
 rtl/uio_bus_arbiter_if.sv | 16 +
 rtl/uio_bus_arbiter_rr_arbiter_core.sv | 28 ++
 rtl/uio_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and constants for the uio pad-bank arbiter.
//   state_t   : arbiter FSM states
//   DIR_*     : requester direction encoding (1 = drive pads)
//   OE_ALL    : pad output enable when the bank is driven
//   dir_oe()  : pad enable pattern that belongs to a bus direction
package uio_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, TURN, XFER, REL} state_t;

  localparam logic       DIR_READ  = 1'b0;
  localparam logic       DIR_WRITE = 1'b1;
  localparam logic [7:0] OE_ALL    = 8'hFF;

  function automatic logic [7:0] dir_oe(input logic dir);
    return (dir == DIR_WRITE) ? OE_ALL : 8'h00;
  endfunction
endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester-side bus of the uio arbiter.
//   req/req_dir/req_last/wdata : per-requester request, direction, last-beat flag, write byte
//   gnt/beat/rdata             : one-hot grant, beat-completed pulse, sampled read byte
// master = requesters, slave = arbiter.
interface uio_bus_arbiter_if #(parameter int NUM_REQ = 4) ();
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      req_dir;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0][7:0] wdata;
  logic [NUM_REQ-1:0]      gnt;
  logic                    beat;
  logic [7:0]              rdata;

  modport master (output req, req_dir, req_last, wdata, input gnt, beat, rdata);
  modport slave  (input req, req_dir, req_last, wdata, output gnt, beat, rdata);
endinterface

// File: rtl/uio_bus_arbiter_rr_arbiter_core.sv
// Combinational round-robin pick: the first set req bit at or after ptr,
// wrapping modulo N, returned one-hot (zero when nothing requests).
//   req : request vector
//   ptr : highest-priority index this round (must be < N)
//   win : one-hot winner
module rr_arbiter_core #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);
  logic [PW-1:0] sel;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    win = '0;
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sel = PW'((int'(ptr) + i) % N);
      if (req[sel]) begin
        win      = '0;
        win[sel] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bank among NUM_REQ requesters.
// Grants one requester for a burst of byte beats, inserts TURNAROUND idle
// cycles (pads released) on direction changes, registers every pad output.
//   clk, rst_n : clock, async active-low reset (pads release immediately)
//   ena        : low aborts any burst and releases the pads
//   bus        : requester interface (slave side)
//   uio_in     : pad input, sampled into rdata on read beats
//   uio_out    : pad output byte; uio_oe : pad enable (all-ones/all-zeros)
module uio_bus_arbiter
  import uio_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  uio_bus_arbiter_if.slave    bus,
  input  logic [7:0]          uio_in,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe
);
  localparam int PW = $clog2(NUM_REQ);

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   gnt, gnt_nxt, pick;
  logic [PW-1:0]        win, win_nxt, pick_idx, rr_ptr, ptr_nxt;
  logic [3:0]           beat_cnt, cnt_nxt;
  logic [1:0]           turn_cnt, turn_nxt;
  logic                 cur_dir, dir_nxt, beat, beat_nxt;
  logic [7:0]           rdata, rdata_nxt, out_nxt, oe_nxt;

  rr_arbiter_core #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req (bus.req),
    .ptr (rr_ptr),
    .win (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  function automatic logic [PW-1:0] after(input logic [PW-1:0] w);
    return (int'(w) == NUM_REQ - 1) ? '0 : w + 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    win_nxt   = win;
    ptr_nxt   = rr_ptr;
    cnt_nxt   = beat_cnt;
    turn_nxt  = turn_cnt;
    dir_nxt   = cur_dir;
    beat_nxt  = 1'b0;
    rdata_nxt = rdata;
    out_nxt   = uio_out;
    oe_nxt    = uio_oe;
    if (!ena) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      oe_nxt    = '0;
      cnt_nxt   = '0;
      dir_nxt   = DIR_READ;
      // An aborted winner loses its turn.
      if (state != IDLE) ptr_nxt = after(win);
    end else begin
      case (state)
        IDLE: begin
          gnt_nxt = '0;
          cnt_nxt = '0;
          if (|bus.req) begin
            gnt_nxt  = pick;
            win_nxt  = pick_idx;
            turn_nxt = '0;
            // Direction is latched here; later req_dir changes are ignored.
            dir_nxt  = bus.req_dir[pick_idx];
            if (bus.req_dir[pick_idx] != cur_dir) begin
              state_nxt = TURN;
              oe_nxt    = '0;
            end else begin
              state_nxt = XFER;
              if (cur_dir == DIR_WRITE) out_nxt = bus.wdata[pick_idx];
            end
          end
        end
        TURN: begin
          if (turn_cnt == 2'(TURNAROUND - 1)) begin
            state_nxt = XFER;
            oe_nxt    = dir_oe(cur_dir);
            if (cur_dir == DIR_WRITE) out_nxt = bus.wdata[win];
          end else begin
            turn_nxt = turn_cnt + 2'd1;
          end
        end
        XFER: begin
          oe_nxt = dir_oe(cur_dir);
          if (bus.req[win]) begin
            beat_nxt = 1'b1;
            cnt_nxt  = beat_cnt + 4'd1;
            if (cur_dir == DIR_WRITE) out_nxt = bus.wdata[win];
            else                      rdata_nxt = uio_in;
            // req_last and the burst limit on the same beat give one exit.
            if (bus.req_last[win] || cnt_nxt == 4'(MAX_BURST)) begin
              state_nxt = REL;
              gnt_nxt   = '0;
            end
          end else begin
            state_nxt = REL;
            gnt_nxt   = '0;
          end
        end
        REL: begin
          // uio_oe keeps the cur_dir pattern so a same-direction follow-up is glitch-free.
          state_nxt = IDLE;
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          ptr_nxt   = after(win);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      win      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      turn_cnt <= '0;
      cur_dir  <= DIR_READ;
      beat     <= 1'b0;
      rdata    <= '0;
      uio_out  <= '0;
      uio_oe   <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      win      <= win_nxt;
      rr_ptr   <= ptr_nxt;
      beat_cnt <= cnt_nxt;
      turn_cnt <= turn_nxt;
      cur_dir  <= dir_nxt;
      beat     <= beat_nxt;
      rdata    <= rdata_nxt;
      uio_out  <= out_nxt;
      uio_oe   <= oe_nxt;
    end
  end

  assign bus.gnt   = gnt;
  assign bus.beat  = beat;
  assign bus.rdata = rdata;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
endmodule

// File: tb/tb_uio_bus_arbiter.sv
module tb_uio_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out, uio_oe;
  int         total = 0;
  int         bad = 0;

  uio_bus_arbiter_if #(.NUM_REQ(4)) bus ();

  uio_bus_arbiter #(.NUM_REQ(4), .TURNAROUND(1), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req, dir, last;
    logic [7:0] wd, uin;
    logic [3:0] gnt;
    logic       beat;
    logic [7:0] oe, out, rd;
  } vec_t;
  vec_t tv[9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #5;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] prev_in;
    int         nbeat;
    bus.req = '0; bus.req_dir = '0; bus.req_last = '0; bus.wdata = '0;

    // write burst of req0 (turnaround from read), then read burst of req1
    tv[0] = '{4'b0001, 4'b0001, 4'b0000, 8'hA5, 8'h00, 4'b0001, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[1] = '{4'b0001, 4'b0001, 4'b0000, 8'hA5, 8'h00, 4'b0001, 1'b0, 8'hFF, 8'hA5, 8'h00};
    tv[2] = '{4'b0001, 4'b0001, 4'b0000, 8'hA5, 8'h00, 4'b0001, 1'b1, 8'hFF, 8'hA5, 8'h00};
    tv[3] = '{4'b0001, 4'b0001, 4'b0001, 8'h5A, 8'h00, 4'b0000, 1'b1, 8'hFF, 8'h5A, 8'h00};
    tv[4] = '{4'b0010, 4'b0000, 4'b0000, 8'h5A, 8'h3C, 4'b0000, 1'b0, 8'hFF, 8'h5A, 8'h00};
    tv[5] = '{4'b0010, 4'b0000, 4'b0000, 8'h5A, 8'h3C, 4'b0010, 1'b0, 8'h00, 8'h5A, 8'h00};
    tv[6] = '{4'b0010, 4'b0000, 4'b0000, 8'h5A, 8'h3C, 4'b0010, 1'b0, 8'h00, 8'h5A, 8'h00};
    tv[7] = '{4'b0010, 4'b0000, 4'b0010, 8'h5A, 8'h3C, 4'b0000, 1'b1, 8'h00, 8'h5A, 8'h3C};
    tv[8] = '{4'b0000, 4'b0000, 4'b0000, 8'h5A, 8'h3C, 4'b0000, 1'b0, 8'h00, 8'h5A, 8'h3C};

    #3;
    do_reset();
    check("rst_gnt", 8'(bus.gnt), 8'h00);
    check("rst_beat", 8'(bus.beat), 8'h00);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_out", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'h00);

    foreach (tv[i]) begin
      bus.req = tv[i].req; bus.req_dir = tv[i].dir; bus.req_last = tv[i].last;
      bus.wdata[0] = tv[i].wd; uio_in = tv[i].uin;
      step();
      check($sformatf("v%0d_gnt", i), 8'(bus.gnt), 8'(tv[i].gnt));
      check($sformatf("v%0d_beat", i), 8'(bus.beat), 8'(tv[i].beat));
      check($sformatf("v%0d_oe", i), uio_oe, tv[i].oe);
      check($sformatf("v%0d_out", i), uio_out, tv[i].out);
      check($sformatf("v%0d_rdata", i), bus.rdata, tv[i].rd);
    end

    // async reset in the middle of a write burst
    bus.req = 4'b0100; bus.req_dir = 4'b0100; bus.req_last = '0; bus.wdata[2] = 8'h77;
    step(); step(); step();
    check("pre_rst_oe", uio_oe, 8'hFF);
    check("pre_rst_beat", 8'(bus.beat), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_oe", uio_oe, 8'h00);
    check("arst_gnt", 8'(bus.gnt), 8'h00);
    check("arst_rdata", bus.rdata, 8'h00);
    check("arst_out", uio_out, 8'h00);
    bus.req = '0; bus.req_dir = '0;
    #2 rst_n = 1'b1;
    step();
    check("post_rst_gnt", 8'(bus.gnt), 8'h00);

    // round robin, all read, bursts capped at 4; grant 1 also raises req_last on beat 4
    bus.req = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      logic [3:0] exp_g;
      exp_g = 4'(1 << (g % 4));
      check($sformatf("rr%0d_gnt", g), 8'(bus.gnt), 8'(exp_g));
      check($sformatf("rr%0d_beat0", g), 8'(bus.beat), 8'h00);
      for (int b = 0; b < 4; b++) begin
        prev_in = 8'(g * 16 + b);
        uio_in = prev_in;
        bus.req_last = (g == 1 && b == 3) ? 4'b1111 : 4'b0000;
        step();
        check($sformatf("rr%0d_b%0d_beat", g, b), 8'(bus.beat), 8'h01);
        check($sformatf("rr%0d_b%0d_rdata", g, b), bus.rdata, prev_in);
        check($sformatf("rr%0d_b%0d_gnt", g, b), 8'(bus.gnt), (b < 3) ? 8'(exp_g) : 8'h00);
      end
      bus.req_last = '0;
      step();
      check($sformatf("rr%0d_gap_gnt", g), 8'(bus.gnt), 8'h00);
      check($sformatf("rr%0d_gap_beat", g), 8'(bus.beat), 8'h00);
      if (g == 4) bus.req = '0;
      step();
    end
    check("rr_end_gnt", 8'(bus.gnt), 8'h00);

    // ena abort on beat 2 of a write burst
    do_reset();
    bus.req = 4'b0011; bus.req_dir = 4'b0011; bus.wdata[0] = 8'h11; bus.wdata[1] = 8'h22;
    step();
    check("ab_gnt0", 8'(bus.gnt), 8'h01);
    check("ab_turn_oe", uio_oe, 8'h00);
    step();
    check("ab_xfer_oe", uio_oe, 8'hFF);
    step();
    check("ab_beat1", 8'(bus.beat), 8'h01);
    check("ab_out1", uio_out, 8'h11);
    ena = 1'b0;
    step();
    check("ab_gnt", 8'(bus.gnt), 8'h00);
    check("ab_oe", uio_oe, 8'h00);
    check("ab_beat", 8'(bus.beat), 8'h00);
    ena = 1'b1;
    step();
    check("ab_next_gnt", 8'(bus.gnt), 8'h02);
    bus.req = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ab_drain%0d_beat", k), 8'(bus.beat), 8'h00);
    end

    // early drop after a single beat
    do_reset();
    bus.req = 4'b0001; bus.req_dir = 4'b0000; uio_in = 8'hC3;
    step();
    check("ed_gnt", 8'(bus.gnt), 8'h01);
    nbeat = 0;
    step();
    nbeat += int'(bus.beat);
    check("ed_rdata", bus.rdata, 8'hC3);
    bus.req = 4'b0010;
    step();
    nbeat += int'(bus.beat);
    check("ed_rel_gnt", 8'(bus.gnt), 8'h00);
    step();
    nbeat += int'(bus.beat);
    check("ed_beats", 8'(nbeat), 8'h01);
    step();
    check("ed_regnt", 8'(bus.gnt), 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
